// File: rtl/audio_sample_pacer.sv
// rtl/audio_sample_pacer.sv - stereo frame FIFO releasing one attenuated/muted frame every DIV clocks.
// Optional AUDIO_PACER_STATS_EN adds a saturating underrun counter with stats_clr.
module audio_sample_pacer #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  parameter int DIV   = 626
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_left,
  input  logic [WIDTH-1:0]         in_right,
  input  logic [3:0]               atten,
  input  logic                     mute,
  output logic [WIDTH-1:0]         audio_l,
  output logic [WIDTH-1:0]         audio_r,
  output logic                     sample_tick,
  output logic                     underrun,
`ifdef AUDIO_PACER_STATS_EN
  input  logic                     stats_clr,
  output logic [15:0]              underrun_count,
`endif
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(DIV);

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   audio_l_q, audio_l_d;
  logic [WIDTH-1:0]   audio_r_q, audio_r_d;
  logic               tick_q, tick_d;
  logic               underrun_q, underrun_d;

  logic               strobe;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [WIDTH-1:0]   head_l;
  logic [WIDTH-1:0]   head_r;

  // Arithmetic shift on the signed view keeps the sign; shifts past WIDTH give all sign bits.
  function automatic logic [WIDTH-1:0] attenuate(input logic [WIDTH-1:0] s, input logic [3:0] sh);
    logic signed [WIDTH-1:0] v;
    v = $signed(s) >>> sh;
    return v;
  endfunction

  assign strobe   = (cnt_q == CW'(DIV - 1));
  assign full     = (fill_q == FW'(DEPTH));
  assign empty    = (fill_q == '0);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = strobe && !empty;
  assign {head_l, head_r} = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d      = strobe ? '0 : cnt_q + CW'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    audio_l_d  = audio_l_q;
    audio_r_d  = audio_r_q;
    tick_d     = 1'b0;
    underrun_d = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      tick_d    = 1'b1;
      audio_l_d = mute ? '0 : attenuate(head_l, atten);
      audio_r_d = mute ? '0 : attenuate(head_r, atten);
    end else if (strobe) begin
      underrun_d = 1'b1;
    end

    if (push && !pop) begin
      fill_d = fill_q + FW'(1);
    end else if (pop && !push) begin
      fill_d = fill_q - FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      audio_l_q  <= '0;
      audio_r_q  <= '0;
      tick_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      audio_l_q  <= audio_l_d;
      audio_r_q  <= audio_r_d;
      tick_q     <= tick_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage is not reset; pointers and fill alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_left, in_right};
    end
  end

`ifdef AUDIO_PACER_STATS_EN
  logic [15:0] underrun_count_q, underrun_count_d;

  always_comb begin
    underrun_count_d = underrun_count_q;
    if (stats_clr) begin
      underrun_count_d = '0;
    end else if (underrun_d && (underrun_count_q != 16'hFFFF)) begin
      underrun_count_d = underrun_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_count_q <= '0;
    end else begin
      underrun_count_q <= underrun_count_d;
    end
  end

  assign underrun_count = underrun_count_q;
`endif

  assign audio_l     = audio_l_q;
  assign audio_r     = audio_r_q;
  assign sample_tick = tick_q;
  assign underrun    = underrun_q;
  assign fill        = fill_q;

endmodule
